// File: rtl/fetch_align_ctrl.sv
// Fetch sequencer and 16-bit parcel aligner feeding the C-extension decompressor.
// Issues word-aligned fetches, buffers returned words as parcels and presents one
// whole instruction (compressed parcel or 32-bit pair) per handshake to decode.
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PARCELS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic        instr_cmp,
    output logic [31:0] instr_pc
);

    localparam int PW = $clog2(PARCELS);
    localparam int CW = PW + 1;
    // Issue only while at least two parcel slots are free; a fetch is only ever
    // launched from IDLE, where nothing is in flight.
    localparam logic [CW-1:0] ISSUE_MAX = CW'(PARCELS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    logic            drop;
    logic            skip;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [15:0]     parcels [PARCELS];

    logic [PW-1:0]   head_nx;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   tail_nx;
    logic [15:0]     par0;
    logic [15:0]     par1;
    logic            head_cmp;
    logic            have_one;
    logic            have_two;
    logic            pop;
    logic            accept;
    logic            can_issue;
    logic            flush_drop;
    logic [CW-1:0]   pop_amt;
    logic [CW-1:0]   push_amt;

    assign head_nx  = head + PW'(1);
    assign tail     = head + count[PW-1:0];
    assign tail_nx  = tail + PW'(1);
    assign par0     = parcels[head];
    assign par1     = parcels[head_nx];

    // Head classification and the decode-facing view; gated by occupancy so an
    // empty buffer never exposes stale or uninitialised parcel contents.
    assign head_cmp    = (par0[1:0] != 2'b11);
    assign have_one    = (count != '0);
    assign have_two    = (count >= CW'(2));
    assign instr_valid = have_one && (head_cmp || have_two);
    assign instr_cmp   = have_one && head_cmp;
    assign instr_raw   = !instr_valid ? 32'h0 :
                         head_cmp     ? {16'h0, par0} : {par1, par0};

    // Flush overrides both pop and push in the cycle it is asserted.
    assign pop      = instr_valid && instr_ready && !flush;
    assign accept   = (state == WAIT) && mem_rvalid && !flush;
    assign pop_amt  = !pop    ? '0 : (head_cmp ? CW'(1) : CW'(2));
    assign push_amt = !accept ? '0 : (skip     ? CW'(1) : CW'(2));

    assign can_issue = !drop && (count <= ISSUE_MAX);

    // A response is still owed after a flush if one was granted and has not yet
    // come back; a response arriving in the flush cycle itself is the stale one.
    assign flush_drop = ((state == WAIT) && !mem_rvalid) ||
                        ((state == REQ)  && mem_gnt)     ||
                        (drop && !mem_rvalid);

    // Control state: fetch FSM, buffer pointers, PCs and the skip/drop flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC & ~32'h3;
            instr_pc <= RESET_PC & ~32'h1;
            skip     <= RESET_PC[1];
            drop     <= 1'b0;
            count    <= '0;
            head     <= '0;
        end else if (flush) begin
            count    <= '0;
            head     <= '0;
            instr_pc <= flush_pc & ~32'h1;
            mem_addr <= flush_pc & ~32'h3;
            skip     <= flush_pc[1];
            drop     <= flush_drop;
            // From IDLE with nothing owed the empty buffer can take a word at
            // once, which gives the one-cycle flush-to-request latency.
            if ((state == IDLE) && !flush_drop) begin
                state   <= REQ;
                mem_req <= 1'b1;
            end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            count    <= count + push_amt - pop_amt;
            head     <= head + pop_amt[PW-1:0];
            instr_pc <= instr_pc + 32'({pop_amt, 1'b0});
            if (accept) begin
                skip <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (drop) begin
                        if (mem_rvalid) begin
                            drop <= 1'b0;
                        end
                    end else if (can_issue) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state    <= IDLE;
                        mem_addr <= mem_addr + 32'd4;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Parcel storage: written only at the tail on an accepted response, low
    // parcel first; the low parcel is dropped when entering mid-word.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (skip) begin
                parcels[tail] <= mem_rdata[31:16];
            end else begin
                parcels[tail]    <= mem_rdata[15:0];
                parcels[tail_nx] <= mem_rdata[31:16];
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl with a small in-order memory responder.
module tb_fetch_align_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_raw;
    logic        instr_cmp;
    logic [31:0] instr_pc;

    fetch_align_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_raw   (instr_raw),
        .instr_cmp   (instr_cmp),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_img [0:255];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'h0;
    int          hs_cnt = 0;
    bit          stray = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: memory responder drives this cycle's response, then the edge.
    task automatic step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (pend) begin
            if (pcnt <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_img[paddr[9:2]];
                pend       = 1'b0;
            end else begin
                pcnt--;
            end
        end
        if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end
        if (mem_req && mem_gnt) begin
            pend  = 1'b1;
            pcnt  = lat;
            paddr = mem_addr;
            hs_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        step();
        flush    = 1'b0;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] raw,
                                input logic cmp, input logic [31:0] pc);
        int n;
        n = 0;
        while (!instr_valid && n < 40) begin
            step();
            n++;
        end
        check_eq({tag, "_vld"}, 32'(instr_valid), 32'd1);
        if (instr_valid) begin
            check_eq({tag, "_raw"}, instr_raw, raw);
            check_eq({tag, "_cmp"}, 32'(instr_cmp), 32'(cmp));
            check_eq({tag, "_pc"}, instr_pc, pc);
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_img[i] = 32'h0;
        mem_img[8'h00] = 32'h0001_4501;
        mem_img[8'h01] = 32'h0000_8082;
        mem_img[8'h40] = 32'h1234_ABCD;
        mem_img[8'h60] = 32'hDEAD_BEEF;
        mem_img[8'h80] = 32'h1111_4505;
        mem_img[8'hC0] = 32'h2202_1101;
        mem_img[8'hC1] = 32'h4402_3301;
        mem_img[8'hC2] = 32'h6602_5501;

        // Reset values
        step();
        step();
        check_eq("rst_req",  32'(mem_req), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_vld",  32'(instr_valid), 32'd0);
        check_eq("rst_raw",  instr_raw, 32'h0);
        check_eq("rst_cmp",  32'(instr_cmp), 32'd0);
        check_eq("rst_pc",   instr_pc, 32'h0);
        rst_n = 1'b1;

        // 1: four compressed parcels from two words
        expect_instr("t1_cli",  32'h0000_4501, 1'b1, 32'h0);
        expect_instr("t1_cnop", 32'h0000_0001, 1'b1, 32'h2);
        expect_instr("t1_cjr",  32'h0000_8082, 1'b1, 32'h4);
        expect_instr("t1_zero", 32'h0000_0000, 1'b1, 32'h6);

        // 2: 32-bit instruction spanning two fetch words
        mem_img[8'h00] = 32'h0093_4501;
        mem_img[8'h01] = 32'h0000_0010;
        do_flush(32'h0);
        check_eq("t2_flush_vld", 32'(instr_valid), 32'd0);
        expect_instr("t2_cli", 32'h0000_4501, 1'b1, 32'h0);
        expect_instr("t2_w32", 32'h0010_0093, 1'b0, 32'h2);

        // 3: halfword redirect from idle, minimum latency
        for (int i = 0; i < 12; i++) step();
        do_flush(32'h0000_0102);
        check_eq("t3_addr", mem_addr, 32'h0000_0100);
        check_eq("t3_req",  32'(mem_req), 32'd1);
        check_eq("t3_vld1", 32'(instr_valid), 32'd0);
        check_eq("t3_pc",   instr_pc, 32'h0000_0102);
        step();
        check_eq("t3_vld2", 32'(instr_valid), 32'd0);
        step();
        check_eq("t3_vld3", 32'(instr_valid), 32'd1);
        expect_instr("t3_first", 32'h0000_1234, 1'b1, 32'h0000_0102);

        // 4: flush while a fetch is outstanding; stale word must vanish
        lat = 4;
        do_flush(32'h0000_0180);
        n = 0;
        while (!(mem_req && mem_gnt) && n < 30) begin
            step();
            n++;
        end
        check_eq("t4_hs_addr", mem_addr, 32'h0000_0180);
        step();
        do_flush(32'h0000_0200);
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_noreq", 32'(mem_req), 32'd0);
            check_eq("t4_novld", 32'(instr_valid), 32'd0);
            step();
        end
        expect_instr("t4_new", 32'h0000_4505, 1'b1, 32'h0000_0200);

        // 5: decode stalled; fetch must stop when the buffer is full
        do_flush(32'h0000_0300);
        hs_cnt = 0;
        for (int i = 0; i < 14; i++) step();
        check_eq("t5_hs",   32'(hs_cnt), 32'd2);
        check_eq("t5_req",  32'(mem_req), 32'd0);
        check_eq("t5_vld",  32'(instr_valid), 32'd1);
        expect_instr("t5_p0", 32'h0000_1101, 1'b1, 32'h0000_0300);
        expect_instr("t5_p1", 32'h0000_2202, 1'b1, 32'h0000_0302);
        expect_instr("t5_p2", 32'h0000_3301, 1'b1, 32'h0000_0304);
        expect_instr("t5_p3", 32'h0000_4402, 1'b1, 32'h0000_0306);
        expect_instr("t5_p4", 32'h0000_5501, 1'b1, 32'h0000_0308);
        expect_instr("t5_p5", 32'h0000_6602, 1'b1, 32'h0000_030A);

        // 6: asynchronous reset while a request is pending
        mem_gnt = 1'b0;
        do_flush(32'h0000_0400);
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        check_eq("t6_req",  32'(mem_req), 32'd1);
        check_eq("t6_addr", mem_addr, 32'h0000_0400);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req",  32'(mem_req), 32'd0);
        check_eq("t6_rst_addr", mem_addr, 32'h0);
        check_eq("t6_rst_vld",  32'(instr_valid), 32'd0);
        check_eq("t6_rst_raw",  instr_raw, 32'h0);
        check_eq("t6_rst_cmp",  32'(instr_cmp), 32'd0);
        check_eq("t6_rst_pc",   instr_pc, 32'h0);
        pend = 1'b0;
        mem_img[8'h00] = 32'h0000_4509;
        step();
        step();
        rst_n = 1'b1;
        stray = 1'b1;
        step();
        stray = 1'b0;
        check_eq("t6_rel_req",  32'(mem_req), 32'd1);
        check_eq("t6_rel_addr", mem_addr, 32'h0);
        check_eq("t6_rel_vld",  32'(instr_valid), 32'd0);
        mem_gnt = 1'b1;
        expect_instr("t6_first", 32'h0000_4509, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
